// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus types and arbiter state encoding.
// Address translation is controlled by the CBUS_ADDR_XLATE_EN macro in the top.
package cbus_rr_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   // kseg0/kseg1 differ from physical only in the top three address bits.
   function automatic logic [31:0] phys_addr(input logic [31:0] vaddr);
      return {3'b000, vaddr[28:0]};
   endfunction

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// Combinational round-robin picker: first set bit of valid scanning from prio upward, wrapping.
// Kept generic so other arbiters (interrupt, TLB refill) can reuse it.
module rr_pick #(
   parameter  int NUM_INPUTS = 4,
   localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] valid,
   input  logic [IDX_W-1:0]      prio,
   output logic                  any,
   output logic [IDX_W-1:0]      idx
);

   logic [IDX_W-1:0] cand;

   // Scan from the far end back toward prio so the nearest valid index is written last.
   always_comb begin
      any  = |valid;
      idx  = '0;
      cand = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(prio) + k) % NUM_INPUTS);
         if (valid[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-input CBus arbiter: whole-transaction grants, round-robin rotation on completion.
// Define CBUS_ADDR_XLATE_EN to fold kseg0/kseg1 addresses to physical on oreq.
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
   output cbus_resp_t [NUM_INPUTS-1:0] iresps,
   output cbus_req_t                   oreq,
   input  cbus_resp_t                  oresp
);

   arb_state_t             state, state_nxt;
   logic [IDX_W-1:0]       grant, grant_nxt;
   logic [IDX_W-1:0]       prio, prio_nxt;
   logic [NUM_INPUTS-1:0]  req_valid;
   logic                   pick_any;
   logic [IDX_W-1:0]       pick_idx;
   cbus_req_t              cur_req;

   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
   end

   rr_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick (
      .valid (req_valid),
      .prio  (prio),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   assign cur_req = ireqs[grant];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         prio  <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         prio  <= prio_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      prio_nxt  = prio;
      oreq      = '0;
      iresps    = '0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_idx;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            iresps[grant] = oresp;
            // A master dropping valid mid-transaction abandons it; abort wins over completion.
            if (!cur_req.valid) begin
               state_nxt = IDLE;
            end else begin
               oreq = cur_req;
`ifdef CBUS_ADDR_XLATE_EN
               oreq.addr = phys_addr(cur_req.addr);
`endif
               if (oresp.ready && oresp.last) begin
                  state_nxt = IDLE;
                  prio_nxt  = (grant == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: directed scenarios then random traffic, checked against a queue-based model.
module tb_cbus_rr_arbiter;
   import cbus_rr_arbiter_pkg::*;

   localparam int N = 4;
`ifdef CBUS_ADDR_XLATE_EN
   localparam logic [31:0] XL_EXP = 32'h0000_1000;
`else
   localparam logic [31:0] XL_EXP = 32'hA000_1000;
`endif

   logic                clk = 1'b0;
   logic                reset;
   cbus_req_t  [N-1:0]  ireqs;
   cbus_resp_t [N-1:0]  iresps;
   cbus_req_t           oreq;
   cbus_resp_t          oresp;

   int checks = 0, errors = 0, cyc = 0;
   bit m_busy;
   int m_grant, m_prio, beat, done_port;
   int glog[$];

   cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_grant = 0; m_prio = 0; beat = 0;
   endtask

   // Expected outputs follow directly from who holds the bus and whether it still asks for it.
   task automatic check_outputs(input string tag);
      cbus_req_t        e_req;
      cbus_resp_t [N-1:0] e_resp;
      e_req  = '0;
      e_resp = '0;
      if (m_busy) begin
         e_resp[m_grant] = oresp;
         if (ireqs[m_grant].valid) begin
            e_req = ireqs[m_grant];
`ifdef CBUS_ADDR_XLATE_EN
            e_req.addr[31:29] = 3'b000;
`endif
         end
      end
      chk({tag, ".oreq"}, 256'(e_req) ^ 256'(e_req) ^ 256'(oreq), 256'(e_req));
      chk({tag, ".iresps"}, 256'(iresps), 256'(e_resp));
   endtask

   task automatic model_edge();
      done_port = -1;
      if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_prio + k) % N;
            if (ireqs[i].valid) begin
               m_busy = 1'b1; m_grant = i; beat = 0;
               glog.push_back(i);
               break;
            end
         end
      end else if (!ireqs[m_grant].valid) begin
         m_busy = 1'b0;
      end else if (oresp.ready) begin
         if (oresp.last) begin
            m_busy = 1'b0;
            m_prio = (m_grant + 1) % N;
            done_port = m_grant;
         end else begin
            beat++;
         end
      end
   endtask

   // Called at posedge+1; checks mid-cycle, advances the model across the edge.
   task automatic step(input string tag);
      #3;
      check_outputs(tag);
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Downstream slave: answers the granted master, garbage in IDLE to prove it is ignored.
   task automatic drive_slave(input bit rnd);
      if (m_busy && ireqs[m_grant].valid) begin
         oresp.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         oresp.last  = oresp.ready && (beat == int'(ireqs[m_grant].len));
      end else begin
         oresp.ready = 1'($urandom_range(0, 1));
         oresp.last  = 1'($urandom_range(0, 1));
      end
      oresp.data = $urandom;
   endtask

   task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [3:0] l);
      ireqs[i].valid    = v;
      ireqs[i].is_write = 1'($urandom);
      ireqs[i].size     = 3'($urandom);
      ireqs[i].addr     = a;
      ireqs[i].strobe   = 4'($urandom);
      ireqs[i].data     = $urandom;
      ireqs[i].len      = l;
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (m_busy && n < budget) begin
         drive_slave(1'b0);
         step(tag);
         n++;
      end
      chk({tag, ".timeout"}, 256'(m_busy), 256'(0));
      oresp = '0;
   endtask

   initial begin
      int base, n;
      bit r, raised;
      reset = 1'b1;
      ireqs = '0;
      oresp = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step("reset");
      step("reset_idle");

      // Round robin: everybody valid, 4-beat bursts
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000_0000 + 32'(i * 16), 4'd3);
      base = glog.size();
      n = 0;
      while (!((glog.size() - base) >= 5 && !m_busy) && n < 200) begin
         drive_slave(1'b0);
         step("rr");
         n++;
      end
      chk("rr.timeout", 256'(n < 200), 256'(1));
      for (int k = 0; k < 5; k++) chk("rr.order", 256'(glog[base + k]), 256'(k % N));
      ireqs = '0;
      oresp = '0;

      // Single beat on port 1
      set_req(1, 1'b1, 32'h8000_0010, 4'd0);
      step("sb_t0");
      chk("sb.valid_t1", 256'(oreq.valid), 256'(1));
      step("sb_t1");
      oresp = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_F00D};
      #1;
      chk("sb.last_t2", 256'(iresps[1].last), 256'(1));
      step("sb_t2");
      ireqs[1].valid = 1'b0;
      oresp = '0;
      #1;
      chk("sb.idle_t3", 256'(oreq.valid), 256'(0));
      step("sb_t3");

      // Burst lock: port 3 waits until two cycles after port 0's last beat
      set_req(0, 1'b1, 32'h0000_2000, 4'd3);
      step("bl_req");
      r = 1'b0; raised = 1'b0; n = 0;
      while (m_busy && n < 50) begin
         oresp.ready = r;
         oresp.last  = r && (beat == 3);
         oresp.data  = $urandom;
         if (!raised && beat >= 1) begin
            set_req(3, 1'b1, 32'h0000_3000, 4'd0);
            raised = 1'b1;
         end
         step("bl");
         r = ~r;
         n++;
      end
      chk("bl.done_port", 256'(done_port), 256'(0));
      ireqs[0].valid = 1'b0;
      oresp = '0;
      #1;
      chk("bl.gap_valid", 256'(oreq.valid), 256'(0));
      step("bl_gap");
      chk("bl.p3_granted", 256'({oreq.valid, oreq.addr[28:0]}), 256'({1'b1, 29'h3000}));
      run_until_idle("bl_p3", 20);
      ireqs[3].valid = 1'b0;
      step("bl_end");

      // Abort: port 2 drops valid mid-burst, prio stays 0
      set_req(2, 1'b1, 32'h0000_4000, 4'd3);
      step("ab_req");
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1234_5678};
      step("ab_beat0");
      ireqs[2].valid = 1'b0;
      oresp = '0;
      #1;
      chk("ab.oreq_zero", 256'(oreq), 256'(0));
      step("ab_drop");
      set_req(0, 1'b1, 32'h0000_5000, 4'd0);
      set_req(3, 1'b1, 32'h0000_6000, 4'd0);
      #1;
      chk("ab.idle", 256'(oreq.valid), 256'(0));
      step("ab_arb");
      chk("ab.prio_kept", 256'({oreq.valid, oreq.addr[15:0]}), 256'({1'b1, 16'h5000}));
      run_until_idle("ab_p0", 20);
      ireqs[0].valid = 1'b0;
      step("ab_gap");
      run_until_idle("ab_p3", 20);
      ireqs[3].valid = 1'b0;
      step("ab_end");

      // Translation on port 1 (leaves prio at 2)
      set_req(1, 1'b1, 32'hA000_1000, 4'd0);
      step("xl_req");
      chk("xl.addr", 256'(oreq.addr), 256'(XL_EXP));
      run_until_idle("xl", 20);
      ireqs[1].valid = 1'b0;
      step("xl_end");

      // Async reset mid-burst on port 2
      set_req(2, 1'b1, 32'h0000_7000, 4'd3);
      step("rs_req");
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0BAD_BEEF};
      step("rs_beat0");
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0BAD_BEEF};
      #1;
      reset = 1'b1;
      #1;
      chk("rs.oreq", 256'(oreq), 256'(0));
      chk("rs.iresps", 256'(iresps), 256'(0));
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      oresp = '0;
      set_req(1, 1'b1, 32'h0000_8000, 4'd0);
      step("rs_arb");
      chk("rs.prio0", 256'({oreq.valid, oreq.addr[15:0]}), 256'({1'b1, 16'h8000}));
      run_until_idle("rs_p1", 20);
      ireqs[1].valid = 1'b0;
      step("rs_gap");
      run_until_idle("rs_p2", 20);
      ireqs = '0;
      step("rs_end");

      // Random traffic with occasional aborts
      for (int c = 0; c < 600; c++) begin
         drive_slave(1'b1);
         step("rand");
         for (int i = 0; i < N; i++) begin
            if (ireqs[i].valid) begin
               if (done_port == i || $urandom_range(0, 63) == 0) ireqs[i].valid = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               set_req(i, 1'b1, $urandom, 4'($urandom_range(0, 3)));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Parametrised N-input CBus arbiter that sits between the core's cached and uncached bus converters and the single external `cbus` port. It grants one whole transaction at a time, covering every beat of a burst until the last beat completes. Grants rotate round-robin so no master starves. It optionally folds kseg0/kseg1 virtual addresses to physical on the outgoing request.

## Interface
Parameters:
- `NUM_INPUTS`, default 4: number of upstream CBus masters; legal range 2..8.
- `IDX_W`, default `$clog2(NUM_INPUTS)`: grant index width. Derived; not overridden.

Ports:
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `ireqs`, in, `cbus_req_t [NUM_INPUTS-1:0]`: upstream requests. Index 0 has the highest initial priority.
- `iresps`, out, `cbus_resp_t [NUM_INPUTS-1:0]`: upstream responses.
- `oreq`, out, `cbus_req_t`: downstream request.
- `oresp`, in, `cbus_resp_t`: downstream response.

## Operation
- FSM states are IDLE and BUSY. Registers are `state`, `grant` (IDX_W bits) and `prio` (IDX_W bits, the round-robin pointer).
- In IDLE, if any `ireqs[i].valid` is set:
  - Select the first valid index scanning `prio, prio+1, …` modulo NUM_INPUTS.
  - Latch it into `grant` and go to BUSY.
- In BUSY:
  - `oreq` forwards `ireqs[grant]` unchanged, apart from the address rule under Configuration.
  - `iresps[grant]` equals `oresp`. Every other `iresps[j]` is all-zero.
- BUSY exits to IDLE under either of these conditions:
  - Completion: `oresp.ready && oresp.last`. On that edge, `prio` becomes `grant+1` modulo NUM_INPUTS, wrapping from NUM_INPUTS-1 to 0.
  - Abort: `ireqs[grant].valid` is low. This is a protocol violation by the master. `prio` is unchanged, and `oreq` is zero in that same cycle.
- In IDLE, `oreq` and all `iresps` are all-zero.
- If a new valid request appears on the same edge as a completion, it is not granted until the next IDLE cycle. Requests are never granted back-to-back without one IDLE cycle in between.
- The `oresp` fields `ready` and `last` are ignored in IDLE.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `prio`=0, `oreq`=0, all `iresps`=0. Reset asserted mid-burst drops the transaction immediately, with no completion delivered upstream.
- Arbitration latency: a request visible in cycle t drives `oreq.valid` in cycle t+1.
- Turnaround: a completion in cycle t means IDLE in cycle t+1 and the earliest next `oreq.valid` in cycle t+2.
- Outputs in BUSY are combinational from `ireqs[grant]` and `oresp`. There is no added response latency.
- A single-beat transaction (`len`=0) completes on its first `ready && last`.

## Configuration
- `CBUS_ADDR_XLATE_EN` defined: `oreq.addr[31:29]` is forced to 3'b000, mapping kseg0 and kseg1 to physical. Example: 0xBFC0_0000 becomes 0x1FC0_0000.
- `CBUS_ADDR_XLATE_EN` undefined: `oreq.addr` passes through unmodified.
- All other behaviour is identical in both cases.

## Structure
- Shared package (`common.svh`): `cbus_req_t` and `cbus_resp_t` (existing), plus a new `arb_state_t` enum {IDLE, BUSY}.
- Sub-module `rr_pick`: combinational, parametrised by NUM_INPUTS.
  - Inputs: valid vector, `prio`.
  - Outputs: `any` and `idx`.
  - Reused by future interrupt and TLB-refill arbiters.

## Test plan
- **Reset defaults:** assert `reset` asynchronously mid-cycle while BUSY on port 2 → `oreq` and `iresps` read 0 before the next edge; `state`=IDLE and `prio`=0 after release.
- **Single beat, NUM_INPUTS=4:** port 1 read at addr 0x8000_0010, `len`=0 → `oreq.valid` at t+1; `oresp` ready+last at t+2 → `iresps[1].last`=1, and IDLE at t+3.
- **Round-robin fairness:** ports 0–3 all valid continuously, each completing a 4-beat burst → grant order 0,1,2,3,0; no port is granted twice before the others.
- **Burst lock:** port 0 runs `len`=3 (4 beats) with `ready` toggling each cycle; port 3 raises valid at beat 1 → port 3 is not granted until 2 cycles after port 0's last beat.
- **Abort:** port 2 drops valid mid-burst → `oreq`=0 that cycle, IDLE next cycle, `prio` unchanged.
- **Translation:** addr 0xA000_1000 → `oreq.addr`=0x0000_1000 with `CBUS_ADDR_XLATE_EN` defined, and 0xA000_1000 without it.
